// File: rtl/i2c_sensor_poller_pkg.sv
// Shared constants and state encodings for the I2C sensor poller and its transaction launcher.
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR = 7'h48;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CFG  = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_EVAL,
    ST_WAIT_PERIOD
  } poller_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_WAIT_BUSY,
    L_WAIT_DONE,
    L_DRAIN
  } launch_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_sensor_poller_if.sv
// Command/status bundle between the poller and the downstream I2C master.
interface i2c_sensor_poller_if;
  logic        m_start;
  logic        m_op_read;
  logic [1:0]  m_reg_addr;
  logic [15:0] m_wr_word;
  logic [15:0] m_rd_word;
  logic        m_busy;
  logic        m_nack_abort;

  modport master (
    output m_start, m_op_read, m_reg_addr, m_wr_word,
    input  m_rd_word, m_busy, m_nack_abort
  );

  modport slave (
    input  m_start, m_op_read, m_reg_addr, m_wr_word,
    output m_rd_word, m_busy, m_nack_abort
  );
endinterface

// File: rtl/i2c_sensor_poller_launcher.sv
// One I2C master transaction: start/busy handshake plus a launch-to-busy-fall watchdog.
module i2c_txn_launcher
  import i2c_pkg::*;
#(
  parameter int unsigned XFER_TO_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        op,
  input  logic [1:0]  reg_ptr,
  input  logic [15:0] word,
  output logic        done,
  output logic        fail,
  output logic        started,
  output logic [15:0] data,
  i2c_sensor_poller_if.master bus
);

  localparam int unsigned WDW = $clog2(XFER_TO_CYCLES + 1);

  launch_state_t  state, state_nx;
  logic [WDW-1:0] wd;
  logic           timeout;

  assign timeout = (wd >= WDW'(XFER_TO_CYCLES));
  assign started = (state == L_WAIT_DONE);
  assign data    = bus.m_rd_word;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= L_IDLE;
    else        state <= state_nx;
  end

  // done/fail are combinational so the caller captures rd_word/nack the cycle busy falls
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    fail     = 1'b0;
    case (state)
      L_IDLE:      if (go) state_nx = L_WAIT_BUSY;
      L_WAIT_BUSY: begin
        if (timeout)         state_nx = L_DRAIN;
        else if (bus.m_busy) state_nx = L_WAIT_DONE;
      end
      L_WAIT_DONE: begin
        if (!bus.m_busy) begin
          done     = 1'b1;
          fail     = bus.m_nack_abort;
          state_nx = L_IDLE;
        end else if (timeout) begin
          state_nx = L_DRAIN;
        end
      end
      L_DRAIN: begin
        if (!bus.m_busy) begin
          done     = 1'b1;
          fail     = 1'b1;
          state_nx = L_IDLE;
        end
      end
      default: state_nx = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.m_start    <= 1'b0;
      bus.m_op_read  <= 1'b0;
      bus.m_reg_addr <= 2'd0;
      bus.m_wr_word  <= 16'd0;
      wd             <= '0;
    end else begin
      if (state == L_IDLE) begin
        if (go) begin
          bus.m_start    <= 1'b1;
          bus.m_op_read  <= op;
          bus.m_reg_addr <= reg_ptr;
          bus.m_wr_word  <= word;
          wd             <= WDW'(1);
        end
      end else if (!timeout) begin
        wd <= wd + WDW'(1);
      end
      // master ticks slowly: start stays up until busy is seen or the watchdog gives up
      if (state == L_WAIT_BUSY && (bus.m_busy || timeout))
        bus.m_start <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_sensor_poller.sv
// Sensor poll sequencer: config write once, then periodic data reads with retry/err tracking.
// Optional threshold alarm with hysteresis enabled by defining POLLER_ALARM_EN.
module i2c_sensor_poller
  import i2c_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = 10_000_000,
  parameter logic [1:0]  CFG_REG        = REG_CFG,
  parameter logic [15:0] CFG_WORD       = 16'h60A0,
  parameter logic [1:0]  DATA_REG       = REG_DATA,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned XFER_TO_CYCLES = 200_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  i2c_sensor_poller_if.master mbus,
  output logic [15:0]        sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic               dev_err,
  input  logic signed [15:0] thr_hi,
  input  logic signed [15:0] thr_lo,
  output logic               alarm
);

  localparam int unsigned TW = $clog2(POLL_CYCLES + 1);

  poller_state_t state, state_nx;
  logic [TW-1:0] timer;
  logic          period_up;
  logic          cfg_done;
  logic [3:0]    retry_cnt;
  logic          res_fail;
  logic [15:0]   res_data;
  logic          go, l_done, l_fail, l_started;
  logic [15:0]   l_data;
  logic          load;

  assign period_up = (timer >= TW'(POLL_CYCLES - 1));
  assign load      = (state == ST_EVAL) && !res_fail && cfg_done;

  i2c_txn_launcher #(.XFER_TO_CYCLES(XFER_TO_CYCLES)) u_launch (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .op      (cfg_done),
    .reg_ptr (cfg_done ? DATA_REG : CFG_REG),
    .word    (CFG_WORD),
    .done    (l_done),
    .fail    (l_fail),
    .started (l_started),
    .data    (l_data),
    .bus     (mbus)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    case (state)
      ST_IDLE:      if (en) state_nx = ST_LAUNCH;
      ST_LAUNCH: begin
        go       = 1'b1;
        state_nx = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (l_done)         state_nx = ST_EVAL;
        else if (l_started) state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (l_done) state_nx = ST_EVAL;
      // a good cfg write chains straight into the first read; an overdue period relaunches now
      ST_EVAL: begin
        if (!en)                      state_nx = ST_WAIT_PERIOD;
        else if (!res_fail && !cfg_done) state_nx = ST_LAUNCH;
        else if (period_up)           state_nx = ST_LAUNCH;
        else                          state_nx = ST_WAIT_PERIOD;
      end
      ST_WAIT_PERIOD: begin
        if (!en)            state_nx = ST_IDLE;
        else if (period_up) state_nx = ST_LAUNCH;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer        <= '0;
      cfg_done     <= 1'b0;
      retry_cnt    <= 4'd0;
      res_fail     <= 1'b0;
      res_data     <= 16'd0;
      sample_data  <= 16'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      dev_err      <= 1'b0;
    end else begin
      if (state == ST_LAUNCH) timer <= TW'(1);
      else if (!period_up)    timer <= timer + TW'(1);

      if ((state == ST_WAIT_BUSY || state == ST_WAIT_DONE) && l_done) begin
        res_fail <= l_fail;
        res_data <= l_data;
      end

      if (sample_valid && sample_ready) sample_valid <= 1'b0;

      if (state == ST_EVAL) begin
        if (res_fail) begin
          retry_cnt <= sat_inc4(retry_cnt);
          if (sat_inc4(retry_cnt) >= 4'(MAX_RETRY)) dev_err <= 1'b1;
        end else begin
          retry_cnt <= 4'd0;
          if (!cfg_done) cfg_done <= 1'b1;
        end
      end

      if (load) begin
        sample_data  <= res_data;
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready) overrun <= 1'b1;
      end

      if (!en && (state == ST_IDLE || state == ST_WAIT_PERIOD)) begin
        cfg_done  <= 1'b0;
        retry_cnt <= 4'd0;
        overrun   <= 1'b0;
        dev_err   <= 1'b0;
      end
    end
  end

`ifdef POLLER_ALARM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (load) begin
      if ($signed(res_data) >= thr_hi)     alarm <= 1'b1;
      else if ($signed(res_data) < thr_lo) alarm <= 1'b0;
    end
  end
`else
  logic unused_thr;
  assign unused_thr = ^{thr_hi, thr_lo};
  assign alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Directed bench: behavioural master model feeds an expected-sample queue checked on each accept.
module tb_i2c_sensor_poller;
  localparam int POLL = 2000;
  localparam int XFER = 1500;

  logic clk = 1'b0;
  logic rst_n, en, sample_ready, sample_valid, overrun, dev_err, alarm;
  logic [15:0] sample_data;
  logic signed [15:0] thr_hi, thr_lo;

  i2c_sensor_poller_if mbus ();

  i2c_sensor_poller #(.POLL_CYCLES(POLL), .XFER_TO_CYCLES(XFER)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mbus(mbus),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .dev_err(dev_err), .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, n_launch = 0, launch_cyc = 0, n_done = 0, drop_cyc = 0, n_acc = 0, n_valid_cyc = 0;
  logic start_d = 1'b0;
  logic [15:0] rd_val = 16'h1234, rd_step = 16'd0;
  bit deaf = 0, stuck = 0, nack_all = 0;
  logic [15:0] exp_q[$];
  logic [18:0] cmd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_launch(input int n, input int budget);
    int t = 0;
    while (n_launch < n && t < budget) begin @(negedge clk); t++; end
    chk("wait_launch", 32'(n_launch >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (n_done < n && t < budget) begin @(negedge clk); t++; end
    chk("wait_done", 32'(n_done >= n), 1);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int t = 0;
    while (n_acc < n && t < budget) begin @(negedge clk); t++; end
    chk("wait_accept", 32'(n_acc >= n), 1);
  endtask

  always @(posedge clk) cyc++;

  // monitor: launches, valid occupancy, and scoreboard pop on every accept
  always @(negedge clk) begin
    if (mbus.m_start && !start_d) begin n_launch++; launch_cyc = cyc; end
    start_d = mbus.m_start;
    if (sample_valid) n_valid_cyc++;
    if (rst_n && sample_valid && sample_ready) begin
      chk("accept_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sample_data", sample_data, exp_q.pop_front());
      n_acc++;
    end
  end

  // abstract I2C master + slave: fixed latency, optional NACK, deaf or stuck-busy faults
  initial begin
    bit hung;
    mbus.m_busy = 1'b0; mbus.m_rd_word = 16'd0; mbus.m_nack_abort = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mbus.m_start && !deaf) begin
        cmd_q.push_back({mbus.m_op_read, mbus.m_reg_addr, mbus.m_wr_word});
        repeat (3) @(negedge clk);
        chk("start_held", mbus.m_start, 1);
        mbus.m_busy = 1'b1; mbus.m_nack_abort = 1'b0;
        repeat (20) @(negedge clk);
        hung = 0;
        while (stuck) begin hung = 1; @(negedge clk); end
        mbus.m_nack_abort = nack_all;
        if (mbus.m_op_read) begin
          mbus.m_rd_word = rd_val;
          if (!nack_all && !hung) exp_q.push_back(rd_val);
          rd_val = rd_val + rd_step;
        end
        mbus.m_busy = 1'b0;
        drop_cyc = cyc;
        n_done++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int a, d0, L, lc, lc2, lc3, v0;
    logic [15:0] last;
    logic [18:0] c;
    rst_n = 1'b0; en = 1'b0; sample_ready = 1'b1;
    thr_hi = 16'sh0500; thr_lo = 16'sh0400;
    repeat (4) @(negedge clk);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_dev_err", dev_err, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_start", mbus.m_start, 0);

    // config write then first read
    rst_n = 1'b1; en = 1'b1;
    wait_launch(2, 500); wait_done(2, 500); wait_acc(1, 50);
    repeat (3) @(negedge clk);
    chk("cmd_count", cmd_q.size(), 2);
    if (cmd_q.size() >= 2) begin
      c = cmd_q.pop_front(); chk("cfg_cmd", c, {1'b0, 2'd1, 16'h60A0});
      c = cmd_q.pop_front(); chk("rd_cmd", c[18:16], 3'b100);
    end
    chk("first_sample", sample_data, 16'h1234);
    chk("valid_after_accept", sample_valid, 0);

    // steady polling with ready tied high
    rd_val = 16'h2000; rd_step = 16'd1;
    a = n_acc; L = n_launch; v0 = n_valid_cyc;
    wait_launch(L + 1, POLL + 100); lc = launch_cyc;
    wait_launch(L + 2, POLL + 100);
    chk("poll_period", launch_cyc - lc, POLL);
    wait_acc(a + 3, 2 * POLL + 200);
    repeat (3) @(negedge clk);
    chk("valid_one_cycle_each", n_valid_cyc - v0, 3);
    chk("no_overrun", overrun, 0);

    // consumer stalls across two loads
    sample_ready = 1'b0; d0 = n_done; a = n_acc;
    wait_done(d0 + 2, 2 * POLL + 200);
    repeat (4) @(negedge clk);
    chk("overrun_set", overrun, 1);
    chk("valid_held", sample_valid, 1);
    chk("q_depth", exp_q.size(), 2);
    last = rd_val - 16'd1;
    chk("latest_sample", sample_data, last);
    en = 1'b0;
    repeat (100) @(negedge clk);
    chk("overrun_cleared", overrun, 0);
    chk("valid_persists", sample_valid, 1);
    chk("data_persists", sample_data, last);
    exp_q.delete(); exp_q.push_back(last); cmd_q.delete();
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_accept", n_acc, a + 1);
    L = n_launch; en = 1'b1;
    wait_launch(L + 2, 500); wait_acc(a + 2, 500);
    chk("recfg_count", 32'(cmd_q.size() >= 1), 1);
    if (cmd_q.size() >= 1) begin
      c = cmd_q.pop_front(); chk("recfg_cmd", c, {1'b0, 2'd1, 16'h60A0});
    end

    // repeated NACKs on reads
    d0 = n_done; nack_all = 1;
    wait_done(d0 + 2, 3 * POLL); lc2 = launch_cyc;
    repeat (4) @(negedge clk);
    chk("dev_err_after2", dev_err, 0);
    wait_done(d0 + 3, 2 * POLL); lc3 = launch_cyc;
    repeat (4) @(negedge clk);
    chk("dev_err_after3", dev_err, 1);
    chk("nack_no_valid", sample_valid, 0);
    chk("retry_period", lc3 - lc2, POLL);
    nack_all = 0; a = n_acc;
    wait_acc(a + 1, 2 * POLL + 100);
    chk("dev_err_sticky", dev_err, 1);
    en = 1'b0;
    repeat (60) @(negedge clk);
    chk("dev_err_clear", dev_err, 0);

    // master never answers: watchdog drops start
    en = 1'b1; a = n_acc;
    wait_acc(a + 1, 1000);
    deaf = 1; L = n_launch;
    wait_launch(L + 1, 2 * POLL + 50); lc = launch_cyc;
    while (cyc < lc + XFER - 10) @(negedge clk);
    chk("start_before_to", mbus.m_start, 1);
    while (cyc < lc + XFER + 5) @(negedge clk);
    chk("start_after_to", mbus.m_start, 0);
    deaf = 0;
    wait_launch(L + 2, 2 * POLL);
    chk("to_retry_period", launch_cyc - lc, POLL);
    wait_acc(a + 2, 200);

    // master stuck busy: no relaunch until it lets go, then relaunch right after EVAL
    stuck = 1; L = n_launch; a = n_acc;
    wait_launch(L + 1, 2 * POLL + 50); lc = launch_cyc;
    while (cyc < lc + 2 * POLL) @(negedge clk);
    chk("no_relaunch", n_launch, L + 1);
    chk("stuck_start_low", mbus.m_start, 0);
    stuck = 0;
    wait_launch(L + 2, 100);
    chk("relaunch_gap", launch_cyc - drop_cyc, 3);
    chk("stuck_no_sample", n_acc, a);
    wait_acc(a + 1, 200);

`ifdef POLLER_ALARM_EN
    rd_step = 16'd0;
    rd_val = 16'h0600; a = n_acc; wait_acc(a + 1, POLL + 200); repeat (2) @(negedge clk);
    chk("alarm_hi", alarm, 1);
    rd_val = 16'h0450; a = n_acc; wait_acc(a + 1, POLL + 200); repeat (2) @(negedge clk);
    chk("alarm_hold", alarm, 1);
    rd_val = 16'h0300; a = n_acc; wait_acc(a + 1, POLL + 200); repeat (2) @(negedge clk);
    chk("alarm_lo", alarm, 0);
`else
    chk("alarm_tied", alarm, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
